// File: rtl/nios_ii_system_cpu_oci_dct_ctrl.sv
// Nios II OCI trace-capture controller: arbitrates two 3-bit frame sources into a packed word.
// Optional macro NIOS_OCI_DCT_RR_ARB_EN selects round-robin arbitration (default: fixed A-over-B).
module nios_ii_system_cpu_oci_dct_ctrl #(
  parameter int unsigned FRAMES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_valid,
  input  logic [2:0]  a_frame,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [2:0]  b_frame,
  output logic        b_ready,
  input  logic        flush,
  input  logic        test_ending,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        dct_valid,
  input  logic        dct_ready,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [29:0] buffer_r;
  logic [29:0] buffer_s;
  logic [3:0]  count_r;
  logic [3:0]  count_s;
  logic [3:0]  count_post_s;
  logic        ending_r;
  logic        valid_r;
  logic        ended_r;
  logic        grant_a_s;
  logic        grant_b_s;
  logic        accept_en_s;
  logic        accept_s;
  logic [2:0]  frame_s;

`ifdef NIOS_OCI_DCT_RR_ARB_EN
  logic last_b_r;

  // Round-robin grant: on contention the source not granted last wins.
  always_comb begin
    grant_a_s = a_valid & (~b_valid | last_b_r);
    grant_b_s = b_valid & (~a_valid | ~last_b_r);
  end

  // Last-grant pointer; reset value makes A win the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_b_r <= 1'b1;
    end else if (accept_s) begin
      last_b_r <= b_ready;
    end else begin
      last_b_r <= last_b_r;
    end
  end
`else
  // Fixed priority grant: A always beats B.
  always_comb begin
    grant_a_s = a_valid;
    grant_b_s = b_valid & ~a_valid;
  end
`endif

  // Readies depend only on state, valids and grant; gated low while in reset.
  always_comb begin
    accept_en_s  = (state_r == ST_FILL) & ~test_ending & ~ending_r;
    a_ready      = reset_n & accept_en_s & grant_a_s;
    b_ready      = reset_n & accept_en_s & grant_b_s;
    accept_s     = a_ready | b_ready;
    frame_s      = a_ready ? a_frame : b_frame;
    count_post_s = count_r + {3'b000, accept_s};
  end

  // Next-state, buffer and count update.
  always_comb begin
    state_s  = state_r;
    buffer_s = buffer_r;
    count_s  = count_r;
    case (state_r)
      ST_FILL: begin
        for (int k = 0; k < int'(FRAMES); k++) begin
          buffer_s[3*k +: 3] = (accept_s && (count_r == 4'(k))) ? frame_s : buffer_r[3*k +: 3];
        end
        count_s = count_post_s;
        if (test_ending || ending_r) begin
          state_s = (count_r != 4'd0) ? ST_EMIT : ST_DONE;
        end else if (count_post_s == 4'(FRAMES)) begin
          state_s = ST_EMIT;
        end else if (flush && (count_post_s != 4'd0)) begin
          state_s = ST_EMIT;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_EMIT: begin
        if (dct_ready) begin
          buffer_s = 30'd0;
          count_s  = 4'd0;
          state_s  = ending_r ? ST_DONE : ST_FILL;
        end else begin
          state_s  = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_s = ST_DONE;
      end
      default: begin
        state_s  = ST_FILL;
        buffer_s = 30'd0;
        count_s  = 4'd0;
      end
    endcase
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_FILL;
      buffer_r <= 30'd0;
      count_r  <= 4'd0;
      ending_r <= 1'b0;
      valid_r  <= 1'b0;
      ended_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      buffer_r <= buffer_s;
      count_r  <= count_s;
      ending_r <= ending_r | test_ending;
      valid_r  <= (state_s == ST_EMIT);
      ended_r  <= (state_s == ST_DONE);
    end
  end

  assign dct_buffer     = buffer_r;
  assign dct_count      = count_r;
  assign dct_valid      = valid_r;
  assign test_has_ended = ended_r;

endmodule

// File: tb/tb_nios_ii_system_cpu_oci_dct_ctrl.sv
// Scoreboard bench for the OCI trace-capture controller (FRAMES = 10).
module tb_nios_ii_system_cpu_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, b_valid;
  logic [2:0]  a_frame, b_frame;
  logic        a_ready, b_ready;
  logic        flush, test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid, dct_ready, test_has_ended;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [33:0] word_q[$];
  logic [3:0]  grant_q[$];
  logic [29:0] exp_buf;
  logic        ga, gb;

  nios_ii_system_cpu_oci_dct_ctrl #(.FRAMES(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_frame(a_frame), .a_ready(a_ready),
    .b_valid(b_valid), .b_frame(b_frame), .b_ready(b_ready),
    .flush(flush), .test_ending(test_ending),
    .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .dct_ready(dct_ready),
    .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one frame from A (src_b=0) or B (src_b=1) and wait for its acceptance.
  task automatic send(input bit src_b, input logic [2:0] f);
    grant_q.push_back({src_b, f});
    if (src_b) begin b_valid = 1'b1; b_frame = f; end
    else begin a_valid = 1'b1; a_frame = f; end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (src_b ? b_ready : a_ready) break;
    end
    chk("accept_wait", {31'd0, (src_b ? b_ready : a_ready)}, 32'd1);
    tick();
    if (src_b) b_valid = 1'b0;
    else a_valid = 1'b0;
  endtask

  // Monitor: compare every handshaken word and every granted frame against the queues.
  always @(negedge clk) begin
    logic [33:0] ew;
    logic [3:0]  eg;
    if (dct_valid && dct_ready) begin
      ew = (word_q.size() > 0) ? word_q.pop_front() : {4'hF, 30'h3FFFFFFF};
      chk("word_count", {28'd0, dct_count}, {28'd0, ew[33:30]});
      chk("word_buffer", {2'd0, dct_buffer}, {2'd0, ew[29:0]});
    end
    if (a_ready || b_ready) begin
      eg = (grant_q.size() > 0) ? grant_q.pop_front() : 4'hF;
      chk("grant", {28'd0, b_ready, (b_ready ? b_frame : a_frame)}, {28'd0, eg});
      chk("ready_onehot", {31'd0, a_ready & b_ready}, 32'd0);
    end
  end

  initial begin
    reset_n = 1'b0; a_valid = 1'b1; b_valid = 1'b0; a_frame = 3'd1; b_frame = 3'd0;
    flush = 1'b0; test_ending = 1'b0; dct_ready = 1'b1;
    @(negedge clk);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_buffer", {2'd0, dct_buffer}, 32'd0);
    chk("rst_count", {28'd0, dct_count}, 32'd0);
    chk("rst_valid", {31'd0, dct_valid}, 32'd0);
    chk("rst_ended", {31'd0, test_has_ended}, 32'd0);
    tick();
    a_valid = 1'b0;
    reset_n = 1'b1;

    // Both sources valid for 4 cycles, then flush the 4-frame word.
    a_valid = 1'b1; a_frame = 3'd1; b_valid = 1'b1; b_frame = 3'd2;
`ifdef NIOS_OCI_DCT_RR_ARB_EN
    grant_q.push_back(4'b0001); grant_q.push_back(4'b1010);
    grant_q.push_back(4'b0001); grant_q.push_back(4'b1010);
    word_q.push_back({4'd4, 30'h451});
`else
    repeat (4) grant_q.push_back(4'b0001);
    word_q.push_back({4'd4, 30'h249});
`endif
    repeat (4) tick();
    a_valid = 1'b0; b_valid = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    tick();

    // A streams 1..10: one full word, dct_valid for exactly one cycle.
    exp_buf = 30'd0;
    for (int k = 0; k < 10; k++) exp_buf[3*k +: 3] = 3'(k + 1);
    word_q.push_back({4'd10, exp_buf});
    for (int k = 0; k < 10; k++) send(1'b0, 3'(k + 1));
    chk("full_valid", {31'd0, dct_valid}, 32'd1);
    chk("full_count", {28'd0, dct_count}, 32'd10);
    tick();
    chk("full_valid_one_cycle", {31'd0, dct_valid}, 32'd0);

    // B sends 5,6,7 then flush.
    word_q.push_back({4'd3, 30'h1F5});
    send(1'b1, 3'd5); send(1'b1, 3'd6); send(1'b1, 3'd7);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_count", {28'd0, dct_count}, 32'd3);
    tick();

    // Downstream stall with both sources waiting.
    dct_ready = 1'b0;
    exp_buf = 30'd0;
    for (int k = 0; k < 10; k++) exp_buf[3*k +: 3] = 3'(k);
    word_q.push_back({4'd10, exp_buf});
    for (int k = 0; k < 10; k++) send(1'b0, 3'(k));
    a_valid = 1'b1; a_frame = 3'd4; b_valid = 1'b1; b_frame = 3'd6;
`ifdef NIOS_OCI_DCT_RR_ARB_EN
    grant_q.push_back(4'b1110); grant_q.push_back(4'b0100);
`else
    grant_q.push_back(4'b0100); grant_q.push_back(4'b1110);
`endif
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, dct_valid}, 32'd1);
      chk("stall_ready", {30'd0, a_ready, b_ready}, 32'd0);
      chk("stall_count", {28'd0, dct_count}, 32'd10);
      chk("stall_buffer", {2'd0, dct_buffer}, {2'd0, exp_buf});
    end
    @(posedge clk); #1;
    dct_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ga = a_ready; gb = b_ready;
      @(posedge clk); #1;
      if (ga) a_valid = 1'b0;
      if (gb) b_valid = 1'b0;
      if (!a_valid && !b_valid) break;
    end
    chk("stall_frames_taken", {30'd0, a_valid, b_valid}, 32'd0);
`ifdef NIOS_OCI_DCT_RR_ARB_EN
    word_q.push_back({4'd2, 30'd38});
`else
    word_q.push_back({4'd2, 30'd52});
`endif
    flush = 1'b1; tick(); flush = 1'b0;
    tick();

    // End of test with 4 frames buffered.
    word_q.push_back({4'd4, 30'h8D1});
    for (int k = 1; k <= 4; k++) send(1'b0, 3'(k));
    test_ending = 1'b1; tick(); test_ending = 1'b0;
    chk("end_valid", {31'd0, dct_valid}, 32'd1);
    chk("end_count", {28'd0, dct_count}, 32'd4);
    tick();
    chk("end_has_ended", {31'd0, test_has_ended}, 32'd1);
    chk("end_valid_low", {31'd0, dct_valid}, 32'd0);
    a_valid = 1'b1; a_frame = 3'd3;
    repeat (3) begin
      @(negedge clk);
      chk("done_a_ready", {31'd0, a_ready}, 32'd0);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("rst2_ended", {31'd0, test_has_ended}, 32'd0);

    // Reset during EMIT with 6 frames.
    dct_ready = 1'b0;
    for (int k = 0; k < 6; k++) send(1'b0, 3'd7);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("pre_rst_count", {28'd0, dct_count}, 32'd6);
    a_valid = 1'b1; a_frame = 3'd5;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, dct_valid}, 32'd0);
    chk("midrst_count", {28'd0, dct_count}, 32'd0);
    chk("midrst_buffer", {2'd0, dct_buffer}, 32'd0);
    chk("midrst_a_ready", {31'd0, a_ready}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    send(1'b0, 3'd5);
    chk("post_rst_count", {28'd0, dct_count}, 32'd1);
    chk("post_rst_buffer", {2'd0, dct_buffer}, 32'd5);
    dct_ready = 1'b1;
    word_q.push_back({4'd1, 30'd5});
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    test_ending = 1'b1; tick(); test_ending = 1'b0;
    chk("empty_end_ended", {31'd0, test_has_ended}, 32'd1);

    repeat (3) tick();
    chk("words_left", 32'(word_q.size()), 32'd0);
    chk("grants_left", 32'(grant_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
